regfile_sb: RTL

Parametrised successor to the single-write, two-read integer register file used by the pipelined core. Adds the following:
- configurable width and depth;
- same-cycle write-to-read bypass;
- a per-register busy scoreboard for hazard detection;
- a sequential zero-initialisation sweep after reset, replacing constant preload.

Sits between decode (reads, issue) and writeback (writes) in the core datapath.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_sb_if.sv | 28 ++
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_sb.sv | 99 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the parametrised register file with scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned ZERO_REG  = 0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback facing bus of the register file: two read ports, one write port, issue.
interface regfile_sb_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5
);
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] ReadData1;
  logic [XLEN-1:0] ReadData2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            RegWrite;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] WriteData;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            ready;

  modport master (
    output rs1, rs2, RegWrite, rd, WriteData, issue_valid, issue_rd,
    input  ReadData1, ReadData2, rs1_busy, rs2_busy, ready
  );

  modport slave (
    input  rs1, rs2, RegWrite, rd, WriteData, issue_valid, issue_rd,
    output ReadData1, ReadData2, rs1_busy, rs2_busy, ready
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, newest producer wins on collision.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          rs1_busy_c,
  output logic          rs2_busy_c
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (run) begin
      for (int r = 1; r < int'(NREGS); r++) begin
        if (issue_valid && (issue_rd == AW'(r))) begin
          busy_nxt[r] = 1'b1;
        end else if (wb_valid && (wb_rd == AW'(r))) begin
          busy_nxt[r] = 1'b0;
        end
      end
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // A writeback in the same cycle already satisfies the hazard.
  assign rs1_busy_c = run && busy[rs1] && !(wb_valid && (wb_rd == rs1));
  assign rs2_busy_c = run && busy[rs2] && !(wb_valid && (wb_rd == rs2));

endmodule

// File: rtl/regfile_sb.sv
// Register file with x0 hardwired, write-to-read bypass, busy scoreboard and post-reset zero sweep.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);

  localparam int unsigned AW = $clog2(NREGS);

  state_t          state;
  logic [AW-1:0]   cnt;
  logic            ready;
  logic [XLEN-1:0] regs [NREGS];
  logic            run_c;
  logic            wr_en_c;
  logic [XLEN-1:0] rdata1_c;
  logic [XLEN-1:0] rdata2_c;
  logic            rs1_busy_c;
  logic            rs2_busy_c;

  assign run_c   = (state == RUN);
  assign wr_en_c = run_c && bus.RegWrite && (bus.rd != AW'(ZERO_REG));

  // Sweep sequencer: INIT walks cnt from 1 to NREGS-1, then RUN until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      cnt   <= AW'(1);
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(NREGS - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN:     ;
        default: state <= INIT;
      endcase
    end
  end

  // Storage has no reset; the sweep provides the zero state.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      regs[cnt] <= '0;
    end else if (wr_en_c) begin
      regs[bus.rd] <= bus.WriteData;
    end
  end

  always_comb begin
    rdata1_c = '0;
    rdata2_c = '0;
    if (run_c) begin
      if (wr_en_c && (bus.rd == bus.rs1)) begin
        rdata1_c = bus.WriteData;
      end else if (bus.rs1 != AW'(ZERO_REG)) begin
        rdata1_c = regs[bus.rs1];
      end
      if (wr_en_c && (bus.rd == bus.rs2)) begin
        rdata2_c = bus.WriteData;
      end else if (bus.rs2 != AW'(ZERO_REG)) begin
        rdata2_c = regs[bus.rs2];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .run         (run_c),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .wb_valid    (bus.RegWrite),
    .wb_rd       (bus.rd),
    .rs1         (bus.rs1),
    .rs2         (bus.rs2),
    .rs1_busy_c  (rs1_busy_c),
    .rs2_busy_c  (rs2_busy_c)
  );

  assign bus.ReadData1 = rdata1_c;
  assign bus.ReadData2 = rdata2_c;
  assign bus.rs1_busy  = rs1_busy_c;
  assign bus.rs2_busy  = rs2_busy_c;
  assign bus.ready     = ready;

endmodule
